// File: rtl/rng_pkg.sv
// Shared types and constants for the rng_fifo_arbiter byte arbiter and its
// round-robin selector.
package rng_pkg;

  localparam int RNG_BYTE_W    = 8;
  localparam int RNG_NREQ_DEF  = 2;
  localparam int RNG_DEPTH_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_GRANT     = 2'd1,
    ST_WRITE     = 2'd2,
    ST_FULL_WAIT = 2'd3
  } rng_state_e;

  // Round-robin successor of requester k among n requesters.
  function automatic int rr_next(input int k, input int n);
    return (k + 1) % n;
  endfunction

endpackage

// File: rtl/rng_rr_select.sv
// Combinational round-robin picker: first asserted request at or after ptr_i,
// wrapping, returned as a one-hot vector (zero when nothing requests).
module rng_rr_select #(
  parameter  int NREQ = 2,
  localparam int PW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [PW-1:0]   ptr_i,
  output logic [NREQ-1:0] grant_o
);

  always_comb begin
    grant_o = '0;
    // Scan farthest-first so the nearest requester after the pointer wins.
    for (int off = NREQ - 1; off >= 0; off--) begin
      if (req_i[(int'(ptr_i) + off) % NREQ]) begin
        grant_o = '0;
        grant_o[(int'(ptr_i) + off) % NREQ] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rng_fifo_arbiter.sv
// Round-robin byte arbiter feeding rng_fifo, with occupancy tracking.
// Define RNG_ARB_STATS_EN to add per-requester saturating grant counters.
module rng_fifo_arbiter
  import rng_pkg::*;
#(
  parameter  int NREQ  = RNG_NREQ_DEF,
  parameter  int DEPTH = RNG_DEPTH_DEF,
  localparam int LW    = $clog2(DEPTH) + 1,
  localparam int PW    = $clog2(NREQ)
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       enable_i,
  input  logic [NREQ-1:0]            req_valid_i,
  input  logic [RNG_BYTE_W*NREQ-1:0] req_data_i,
  output logic [NREQ-1:0]            req_ready_o,
  input  logic                       fifo_read_i,
  output logic                       write,
  output logic [RNG_BYTE_W-1:0]      data_in,
  output logic [LW-1:0]              level_o,
  output logic                       full_o,
  output logic                       empty_o
`ifdef RNG_ARB_STATS_EN
  ,
  output logic [16*NREQ-1:0]         grant_cnt_o
`endif
);

  rng_state_e            state_q, state_d;
  logic [NREQ-1:0]       grant_q, grant_d, sel;
  logic [PW-1:0]         ptr_q, ptr_d;
  logic [RNG_BYTE_W-1:0] byte_q, byte_d;
  logic [LW-1:0]         level_q, level_d;
  logic                  armed_q;
  logic                  handshake, rd_eff, full;

  rng_rr_select #(.NREQ(NREQ)) u_rr_select (
    .req_i   (req_valid_i),
    .ptr_i   (ptr_q),
    .grant_o (sel)
  );

  assign full        = (level_q == LW'(DEPTH));
  assign handshake   = (state_q == ST_GRANT) && |(grant_q & req_valid_i);
  assign rd_eff      = fifo_read_i && (level_q != '0);
  assign write       = (state_q == ST_WRITE);
  assign data_in     = byte_q;
  assign req_ready_o = (state_q == ST_GRANT) ? grant_q : '0;
  assign level_o     = level_q;
  assign full_o      = full;
  assign empty_o     = (level_q == '0);

  always_comb begin
    level_d = level_q;
    if (write && !rd_eff)      level_d = level_q + LW'(1);
    else if (!write && rd_eff) level_d = level_q - LW'(1);
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    byte_d  = byte_q;
    unique case (state_q)
      ST_IDLE: begin
        if (full) begin
          state_d = ST_FULL_WAIT;
        end else if (armed_q && enable_i && |req_valid_i) begin
          state_d = ST_GRANT;
          grant_d = sel;
        end
      end
      ST_GRANT: begin
        state_d = ST_IDLE;
        if (handshake) begin
          state_d = ST_WRITE;
          for (int k = 0; k < NREQ; k++) begin
            if (grant_q[k]) begin
              byte_d = req_data_i[RNG_BYTE_W*k +: RNG_BYTE_W];
              ptr_d  = PW'(rr_next(k, NREQ));
            end
          end
        end
      end
      ST_WRITE:     state_d = (level_d == LW'(DEPTH)) ? ST_FULL_WAIT : ST_IDLE;
      ST_FULL_WAIT: if (fifo_read_i) state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the pre-edge value of every other register.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      ptr_q   <= '0;
      byte_q  <= '0;
      level_q <= '0;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      byte_q  <= byte_d;
      level_q <= level_d;
      // Holds off arbitration for the first edge after reset release.
      armed_q <= 1'b1;
    end
  end

`ifdef RNG_ARB_STATS_EN
  logic [15:0] cnt_q [NREQ];

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int k = 0; k < NREQ; k++) cnt_q[k] <= '0;
    end else if (handshake) begin
      for (int k = 0; k < NREQ; k++) begin
        if (grant_q[k] && cnt_q[k] != 16'hFFFF) cnt_q[k] <= cnt_q[k] + 16'd1;
      end
    end
  end

  always_comb begin
    for (int k = 0; k < NREQ; k++) grant_cnt_o[16*k +: 16] = cnt_q[k];
  end
`endif

endmodule

// File: tb/tb_rng_fifo_arbiter.sv
// Self-checking bench for rng_fifo_arbiter: directed table, corner-case
// sequences, then randomized traffic against a transaction-level model.
module tb_rng_fifo_arbiter;

  localparam int NREQ  = 2;
  localparam int DEPTH = 16;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic              clk_i       = 1'b0;
  logic              rst_i       = 1'b1;
  logic              enable_i    = 1'b0;
  logic [NREQ-1:0]   req_valid_i = '0;
  logic [8*NREQ-1:0] req_data_i  = '0;
  logic              fifo_read_i = 1'b0;
  logic [NREQ-1:0]   req_ready_o;
  logic              write;
  logic [7:0]        data_in;
  logic [LW-1:0]     level_o;
  logic              full_o, empty_o;
`ifdef RNG_ARB_STATS_EN
  logic [16*NREQ-1:0] grant_cnt_o;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  rng_fifo_arbiter #(.NREQ(NREQ), .DEPTH(DEPTH)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .enable_i    (enable_i),
    .req_valid_i (req_valid_i),
    .req_data_i  (req_data_i),
    .req_ready_o (req_ready_o),
    .fifo_read_i (fifo_read_i),
    .write       (write),
    .data_in     (data_in),
    .level_o     (level_o),
    .full_o      (full_o),
    .empty_o     (empty_o)
`ifdef RNG_ARB_STATS_EN
    ,
    .grant_cnt_o (grant_cnt_o)
`endif
  );

  typedef struct {
    logic [NREQ-1:0] valid;
    logic [7:0]      d0;
    logic [7:0]      d1;
    logic [NREQ-1:0] exp_ready;
    logic [7:0]      exp_data;
  } vec_t;

  vec_t tbl [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Reset low for 10 ns, checking the forced output values while it is low.
  task automatic do_reset();
    req_valid_i = '0;
    fifo_read_i = 1'b0;
    rst_i = 1'b0;
    #2;
    check("rst_ready", req_ready_o, 0);
    check("rst_write", write, 0);
    check("rst_data", data_in, 8'h00);
    check("rst_level", level_o, 0);
    check("rst_empty", empty_o, 1);
    check("rst_full", full_o, 0);
    #8;
    rst_i = 1'b1;
  endtask

  task automatic wait_ready(input int budget);
    for (int i = 0; i < budget; i++) begin
      step();
      if (req_ready_o != '0) break;
    end
  endtask

  function automatic int rr_pick(input logic [NREQ-1:0] v, input int p);
    for (int o = 0; o < NREQ; o++) begin
      if (v[(p + o) % NREQ]) return (p + o) % NREQ;
    end
    return -1;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int g, w, idx, k, m_level, m_ptr, prev_level, n_hs;
    logic exp_write, prev_en, prev_ready, ok;
    logic [7:0] exp_byte;
    logic [NREQ-1:0] prev_valid, cur_ready, hs;

    //                valid  d0     d1     ready  data   (pointer starts at 0)
    tbl[0] = '{2'b01, 8'hAA, 8'h00, 2'b01, 8'hAA};
    tbl[1] = '{2'b11, 8'hAA, 8'hFF, 2'b10, 8'hFF};
    tbl[2] = '{2'b11, 8'hAA, 8'hFF, 2'b01, 8'hAA};
    tbl[3] = '{2'b01, 8'h5A, 8'h00, 2'b01, 8'h5A};
    tbl[4] = '{2'b10, 8'h00, 8'hC3, 2'b10, 8'hC3};
    tbl[5] = '{2'b10, 8'h00, 8'h3C, 2'b10, 8'h3C};

    #1;
    enable_i = 1'b1;

    // Reset, then requester 0 alone: no grant on the first edge, 2-cycle latency.
    do_reset();
    req_valid_i = 2'b01;
    req_data_i  = 16'h00AA;
    step();
    check("first_edge_no_grant", req_ready_o, 0);
    step();
    check("solo_ready", req_ready_o, 2'b01);
    step();
    req_valid_i = '0;
    check("solo_write", write, 1);
    check("solo_data", data_in, 8'hAA);
    step();
    check("solo_level", level_o, 1);
    check("solo_write_drop", write, 0);

    // Table-driven round-robin sequence.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      req_valid_i = tbl[i].valid;
      req_data_i  = {tbl[i].d1, tbl[i].d0};
      wait_ready(8);
      check($sformatf("tbl%0d_ready", i), req_ready_o, tbl[i].exp_ready);
      step();
      req_valid_i = '0;
      check($sformatf("tbl%0d_write", i), write, 1);
      check($sformatf("tbl%0d_data", i), data_in, tbl[i].exp_data);
      step();
      check($sformatf("tbl%0d_level", i), level_o, i + 1);
    end

    // Both requesters continuously valid: grants and bytes alternate.
    do_reset();
    req_valid_i = 2'b11;
    req_data_i  = 16'hFFAA;
    g = 0;
    w = 0;
    for (int c = 0; c < 80 && w < 8; c++) begin
      if (req_ready_o != '0) begin
        check("alt_ready", req_ready_o, (g % 2 == 0) ? 2'b01 : 2'b10);
        g++;
      end
      if (write) begin
        check("alt_data", data_in, (w % 2 == 0) ? 8'hAA : 8'hFF);
        w++;
      end
      step();
    end
    check("alt_count", w, 8);

    // Keep pushing until full: no grants while full, one read resumes.
    for (int c = 0; c < 200 && !full_o; c++) step();
    check("fill_full", full_o, 1);
    check("fill_level", level_o, DEPTH);
    check("fill_empty", empty_o, 0);
    for (int c = 0; c < 4; c++) begin
      step();
      check("full_no_grant", req_ready_o, 0);
    end
    fifo_read_i = 1'b1;
    step();
    fifo_read_i = 1'b0;
    check("pop_level", level_o, DEPTH - 1);
    check("pop_full", full_o, 0);
    wait_ready(8);
    check("resume_grant", req_ready_o != '0, 1);
    req_valid_i = '0;

    // Simultaneous write and read at level 5, then read at level 0.
    do_reset();
    req_valid_i = 2'b01;
    req_data_i  = 16'h0011;
    for (int c = 0; c < 60 && level_o != 5; c++) step();
    req_valid_i = '0;
    step();
    check("lvl5_reached", level_o, 5);
    req_valid_i = 2'b01;
    wait_ready(8);
    step();
    req_valid_i = '0;
    check("simul_write", write, 1);
    check("simul_level_before", level_o, 5);
    fifo_read_i = 1'b1;
    step();
    check("simul_level_after", level_o, 5);
    for (int c = 0; c < 5; c++) step();
    check("drain_level", level_o, 0);
    check("drain_empty", empty_o, 1);
    step();
    fifo_read_i = 1'b0;
    check("underflow_level", level_o, 0);
    check("underflow_empty", empty_o, 1);

    // Reset asserted in the middle of the WRITE cycle.
    do_reset();
    req_valid_i = 2'b01;
    req_data_i  = 16'h0077;
    wait_ready(8);
    step();
    req_valid_i = '0;
    check("rstw_write_before", write, 1);
    #2;
    rst_i = 1'b0;
    #1;
    check("rstw_write_drop", write, 0);
    check("rstw_data", data_in, 8'h00);
    check("rstw_level", level_o, 0);
    #7;
    rst_i = 1'b1;
    step();
    check("rstw_level_after", level_o, 0);
    check("rstw_write_after", write, 0);

    // Randomized traffic against a transaction-level reference model.
    do_reset();
    step();
    step();
    m_level    = 0;
    m_ptr      = 0;
    n_hs       = 0;
    exp_write  = 1'b0;
    exp_byte   = '0;
    prev_valid = '0;
    prev_en    = 1'b0;
    prev_ready = 1'b0;
    prev_level = 0;
    for (int t = 0; t < 3000; t++) begin
      check("rnd_write", write, exp_write);
      if (exp_write) check("rnd_data", data_in, exp_byte);
      check("rnd_level", level_o, m_level);
      check("rnd_full", full_o, m_level == DEPTH);
      check("rnd_empty", empty_o, m_level == 0);
      if (req_ready_o != '0) begin
        idx = rr_pick(prev_valid, m_ptr);
        ok  = prev_en && !prev_ready && (prev_level < DEPTH) && (idx >= 0);
        check("rnd_grant_allowed", ok, 1);
        if (idx >= 0) check("rnd_grant_rr", req_ready_o, 32'(1) << idx);
      end
      cur_ready = req_ready_o;

      enable_i    = ($urandom_range(0, 9) != 0);
      req_valid_i = NREQ'($urandom_range(0, 3));
      req_data_i  = 16'($urandom);
      fifo_read_i = ($urandom_range(0, 3) == 0);

      hs = cur_ready & req_valid_i;
      prev_level = m_level;
      if (exp_write && !(fifo_read_i && m_level != 0)) m_level++;
      else if (!exp_write && fifo_read_i && m_level != 0) m_level--;
      if (hs != '0) begin
        k = rr_pick(hs, 0);
        exp_byte = req_data_i[8*k +: 8];
        m_ptr = (k + 1) % NREQ;
        n_hs++;
      end
      exp_write  = (hs != '0);
      prev_valid = req_valid_i;
      prev_en    = enable_i;
      prev_ready = (cur_ready != '0);
      step();
    end
    check("rnd_activity", n_hs > 100, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rng_fifo_arbiter.md
RNG_FIFO_ARBITER -- requirements
Module: rng_fifo_arbiter

Interface
REQ-001 Parameter NREQ, default 2, sets the number of byte requesters (legal range 2..4).
REQ-002 Parameter DEPTH, default 16, sets the downstream rng_fifo capacity in bytes (power of two, 4..256).
REQ-003 clk_i  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_i  input  1  reset, asynchronous and active-low.
REQ-005 enable_i  input  1  when 0, the block issues no new grants; an in-flight write completes.
REQ-006 req_valid_i  input  NREQ  per-requester byte-available flag.
REQ-007 req_data_i  input  8*NREQ  per-requester byte; requester k occupies bits [8k+7:8k].
REQ-008 req_ready_o  output  NREQ  one-hot or zero grant; a byte transfers when valid and ready are both 1 in the same cycle.
REQ-009 fifo_read_i  input  1  consumer pop strobe on rng_fifo, one byte per cycle.
REQ-010 write  output  1  write strobe to rng_fifo.
REQ-011 data_in  output  8  byte to rng_fifo, valid while write is 1.
REQ-012 level_o  output  clog2(DEPTH)+1  tracked FIFO occupancy.
REQ-013 full_o / empty_o  output  1 each  level_o==DEPTH / level_o==0.

Function
REQ-014 The FSM SHALL have states IDLE, GRANT, WRITE and FULL_WAIT.
REQ-015 IDLE->GRANT when enable_i=1, any req_valid_i=1 and level_o<DEPTH; IDLE->FULL_WAIT when level_o==DEPTH.
REQ-016 In GRANT, req_ready_o SHALL assert for exactly one cycle to the requester selected round-robin, starting from the index after the last granted one.
REQ-017 If the granted requester drops valid during GRANT, the FSM SHALL return to IDLE with no write and no pointer update.
REQ-018 On handshake, the byte SHALL be registered and write=1, data_in=byte SHALL appear in the following cycle (WRITE state), giving 2-cycle valid-to-write latency from IDLE.
REQ-019 WRITE SHALL last one cycle and go to IDLE, or to FULL_WAIT if the write fills the FIFO.
REQ-020 FULL_WAIT->IDLE on the first cycle fifo_read_i=1.
REQ-021 level_o SHALL increment on write, decrement on fifo_read_i when nonzero, and remain unchanged when both occur in the same cycle.
REQ-022 fifo_read_i with level_o==0 SHALL be ignored (no underflow).
REQ-023 The round-robin pointer SHALL advance only on a completed handshake and wrap from NREQ-1 to 0.
REQ-024 At most one byte SHALL be in flight, so level_o never exceeds DEPTH.

Reset
REQ-025 rst_i=0 SHALL immediately force: state IDLE, req_ready_o=0, write=0, data_in=8'h00, level_o=0, empty_o=1, full_o=0, pointer=0.
REQ-026 Reset asserted mid-WRITE SHALL drop write in the same instant, and the pending byte SHALL be discarded.
REQ-027 After rst_i rises, the first grant SHALL occur no earlier than the second rising edge.

Configuration
REQ-028 With RNG_ARB_STATS_EN defined, the block SHALL add output grant_cnt_o (16*NREQ): per-requester saturating 16-bit handshake counters, cleared by reset.
REQ-029 Without RNG_ARB_STATS_EN, the port and counters SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-030 Package rng_pkg SHALL hold the FSM state enum, the byte-width constant (8) and the default NREQ/DEPTH constants.
REQ-031 Round-robin selection SHALL be a sub-module rng_rr_select (request vector + pointer in, one-hot grant out, combinational).

Verification
REQ-032 Reset pulse low for 10 ns, then release -> all outputs at their reset values; no grant on the first edge.
REQ-033 Requester 0 alone, valid with 8'hAA -> req_ready_o=01, then write=1, data_in=8'hAA one cycle later, level_o=1.
REQ-034 Both valid continuously (8'hAA, 8'hFF) -> grants alternate 01,10,01,…; written bytes alternate AA,FF.
REQ-035 Fill to DEPTH=16 with no reads -> full_o=1, state FULL_WAIT, no grants; one fifo_read_i pulse -> level_o=15, grants resume.
REQ-036 write and fifo_read_i in the same cycle at level 5 -> level_o stays 5; fifo_read_i at level 0 -> level_o stays 0.
REQ-037 rst_i low during WRITE -> write drops immediately; level_o=0 after release.
